// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
//  Module   : mem_requester
//  Purpose  : Bus-initiator front end for the Memory block. Turns a single-
//             cycle CPU request into a Memory transaction (strobe, address,
//             tri-state write data), waits for rdyMem, captures read data,
//             reports completion with a one-cycle done pulse and aborts a
//             hung transaction after TIMEOUT wait cycles.
//  Ports    : clk, rst (async, active-low)
//             cpu_req/cpu_we/cpu_addr/cpu_wdata  - request from control unit
//             cpu_busy/cpu_done/cpu_err/cpu_rdata - status / read data back
//             readMem/writeMem/addrBus/inBus      - drive side to Memory
//             rdyMem/outBus                       - response from Memory
//  Revision : 1.0 - initial release
// ============================================================================
module mem_requester #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              readMem,
    output logic              writeMem,
    output logic [ADDR_W-1:0] addrBus,
    inout  wire  [DATA_W-1:0] inBus,
    input  logic              rdyMem,
    input  logic [DATA_W-1:0] outBus
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    // Count value seen on the TIMEOUT-th consecutive not-ready WAIT edge.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_drive;

    // Enable decoded purely from registers, so the bus driver never glitches.
    assign w_drive = r_we && (r_state != S_IDLE);
    assign inBus   = w_drive ? r_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            readMem   <= 1'b0;
            writeMem  <= 1'b0;
            addrBus   <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_state  <= S_STROBE;
                        r_we     <= cpu_we;
                        r_wdata  <= cpu_wdata;
                        addrBus  <= cpu_addr;
                        readMem  <= !cpu_we;
                        writeMem <= cpu_we;
                        cpu_busy <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_STROBE: begin
                    // rdyMem deliberately not looked at here: a ready left
                    // over from the previous op must not complete this one.
                    readMem  <= 1'b0;
                    writeMem <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (rdyMem) begin
                        if (!r_we) begin
                            cpu_rdata <= outBus;
                        end
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b0;
                        cpu_busy <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                        cpu_busy <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    readMem  <= 1'b0;
                    writeMem <= 1'b0;
                    cpu_busy <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_requester
//  Purpose  : Self-checking bench for mem_requester: Memory responder model,
//             shadow memory scoreboard, directed write/read/latency/timeout/
//             reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_requester;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 4;
    // Pullups on inBus make an undriven (high-Z) bus read back as all ones.
    localparam logic [DATA_W-1:0] c_HIZ = 16'hFFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_busy, cpu_done, cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic              readMem, writeMem;
    logic [ADDR_W-1:0] addrBus;
    wire  [DATA_W-1:0] inBus;
    logic              rdyMem = 1'b0;
    logic [DATA_W-1:0] outBus = '0;

    for (genvar g = 0; g < DATA_W; g++) begin : g_pull
        pullup pu (inBus[g]);
    end

    mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .readMem(readMem), .writeMem(writeMem), .addrBus(addrBus), .inBus(inBus),
        .rdyMem(rdyMem), .outBus(outBus)
    );

    always #5 clk = ~clk;

    // Memory responder: answers one cycle after seeing a strobe, so the
    // requester samples rdyMem at E2 (minimum latency).
    logic [DATA_W-1:0] mem [256];
    logic              respond = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdyMem <= 1'b0;
        end else begin
            rdyMem <= 1'b0;
            if (respond && (readMem || writeMem)) begin
                rdyMem <= 1'b1;
                if (writeMem) mem[addrBus] <= inBus;
                else          outBus       <= mem[addrBus];
            end
        end
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] shadow [256];
    logic [DATA_W-1:0] lastRdata = '0;
    int                nAssert = 0;
    int                nFail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, starting and ending 1 time unit after a posedge.
    task automatic runOp(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic expErr, input int expLat);
        exp_t e;
        int   lat, rdP, wrP;
        e.we   = we;
        e.addr = addr;
        e.err  = expErr;
        e.data = (expErr || we) ? lastRdata : shadow[addr];
        if (we && !expErr) shadow[addr] = wdata;
        sbq.push_back(e);

        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = we ? wdata : 16'h5A5A;
        cpu_req   = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 0; rdP = 0; wrP = 0;
        while (lat < 64 && !cpu_done) begin
            rdP += int'(readMem);
            wrP += int'(writeMem);
            check({tag, " busy"}, cpu_busy, 1);
            check({tag, " addrBus"}, addrBus, addr);
            check({tag, " inBus"}, inBus, we ? wdata : c_HIZ);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " done"}, cpu_done, 1);
        e = sbq.pop_front();
        check({tag, " latency"}, lat, expLat);
        check({tag, " err"}, cpu_err, e.err);
        check({tag, " rdata"}, cpu_rdata, e.data);
        check({tag, " readPulses"}, rdP, e.we ? 0 : 1);
        check({tag, " writePulses"}, wrP, e.we ? 1 : 0);
        check({tag, " idle busy"}, cpu_busy, 0);
        check({tag, " idle inBus"}, inBus, c_HIZ);
        if (!we && !expErr) lastRdata = e.data;
        @(posedge clk); #1;
        check({tag, " donePulse"}, cpu_done, 0);
        check({tag, " errHold"}, cpu_err, expErr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", cpu_busy, 0);
        check("rst done", cpu_done, 0);
        check("rst err", cpu_err, 0);
        check("rst readMem", readMem, 0);
        check("rst writeMem", writeMem, 0);
        check("rst addrBus", addrBus, 0);
        check("rst rdata", cpu_rdata, 0);
        check("rst inBus", inBus, c_HIZ);
        rst = 1'b1;
        @(posedge clk); #1;

        // Writes then reads
        runOp("wr3",   1'b1, 8'd3,   16'h000C, 1'b0, 2);
        runOp("wr10",  1'b1, 8'd10,  16'hFE0F, 1'b0, 2);
        runOp("wr255", 1'b1, 8'd255, 16'hFFFF, 1'b0, 2);
        runOp("rd3",   1'b0, 8'd3,   16'h0000, 1'b0, 2);
        runOp("rd10",  1'b0, 8'd10,  16'h0000, 1'b0, 2);
        runOp("rd255", 1'b0, 8'd255, 16'h0000, 1'b0, 2);

        // Minimum latency with a request held high while busy
        e = '{we: 1'b1, addr: 8'd50, data: 16'h1111, err: 1'b0};
        sbq.push_back(e);
        shadow[50] = 16'h1111;
        e = '{we: 1'b0, addr: 8'd50, data: 16'h1111, err: 1'b0};
        sbq.push_back(e);
        cpu_we = 1'b1; cpu_addr = 8'd50; cpu_wdata = 16'h1111; cpu_req = 1'b1;
        @(posedge clk); #1;                       // after E0
        check("lat E0 writeMem", writeMem, 1);
        cpu_we = 1'b0;                            // held request becomes a read
        @(posedge clk); #1;                       // after E1
        check("lat E1 done", cpu_done, 0);
        check("lat E1 strobes", {readMem, writeMem}, 2'b00);
        @(posedge clk); #1;                       // after E2
        e = sbq.pop_front();
        check("lat E2 done", cpu_done, 1);
        check("lat E2 err", cpu_err, e.err);
        check("lat E2 strobes", {readMem, writeMem}, 2'b00);
        @(posedge clk); #1;                       // after E3: second op accepted
        cpu_req = 1'b0;
        check("lat E3 done", cpu_done, 0);
        check("lat E3 readMem", readMem, 1);
        check("lat E3 busy", cpu_busy, 1);
        @(posedge clk); #1;
        check("lat E4 readMem", readMem, 0);
        @(posedge clk); #1;
        e = sbq.pop_front();
        check("lat2 done", cpu_done, 1);
        check("lat2 rdata", cpu_rdata, e.data);
        lastRdata = e.data;
        @(posedge clk); #1;

        // Timeout with rdyMem stuck low, then a normal op
        respond = 1'b0;
        runOp("tmo rd20", 1'b0, 8'd20, 16'h0000, 1'b1, 1 + TIMEOUT);
        respond = 1'b1;
        runOp("post-tmo rd3", 1'b0, 8'd3, 16'h0000, 1'b0, 2);

        // Reset in WAIT of a write
        respond = 1'b0;
        cpu_we = 1'b1; cpu_addr = 8'd10; cpu_wdata = 16'hABCD; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                       // in WAIT
        check("rstmid inBus driven", inBus, 16'hABCD);
        #2 rst = 1'b0;
        #1;
        check("rstmid writeMem", writeMem, 0);
        check("rstmid inBus", inBus, c_HIZ);
        check("rstmid busy", cpu_busy, 0);
        check("rstmid addrBus", addrBus, 0);
        check("rstmid rdata", cpu_rdata, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rstmid held done", cpu_done, 0);
        end
        rst = 1'b1;
        respond = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("rstmid after done", cpu_done, 0);
            check("rstmid after busy", cpu_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_requester.md
# mem_requester

Bus-initiator front end for the `Memory` block. It turns a single-cycle request from the datapath or controller into a `Memory` transaction:
- drives the `readMem`/`writeMem` strobes, `addrBus`, and the tri-state `inBus`;
- waits for `rdyMem`, captures `outBus` on reads, and reports completion with a one-cycle done pulse;
- aborts a hung transaction after a bounded wait.

It sits between the CPU control unit and `Memory`. It is the only agent allowed to drive `inBus`.

## Interface
- `ADDR_W`, 8, address width (matches `addrBus`)
- `DATA_W`, 16, data width (matches `inBus`/`outBus`)
- `TIMEOUT`, 16, consecutive WAIT cycles without `rdyMem` before abort (≥1)

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-low
- `cpu_req`  in  1  request strobe, sampled in IDLE only
- `cpu_we`  in  1  1 = write, 0 = read, sampled with `cpu_req`
- `cpu_addr`  in  ADDR_W  request address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_busy`  out  1  high while a transaction is in flight (state ≠ IDLE)
- `cpu_done`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  valid with `cpu_done`; 1 = timed out
- `cpu_rdata`  out  DATA_W  last successfully read word
- `readMem`  out  1  read strobe to `Memory`
- `writeMem`  out  1  write strobe to `Memory`
- `addrBus`  out  ADDR_W  address to `Memory`
- `inBus`  inout  DATA_W  write data to `Memory`; high-Z unless this block is writing
- `rdyMem`  in  1  `Memory` completion
- `outBus`  in  DATA_W  `Memory` read data, valid when `rdyMem` = 1

## Operation
- **State machine:** three states, IDLE → STROBE → WAIT → IDLE.
- **IDLE:**
  - On a posedge with `cpu_req` = 1, register `cpu_addr`, `cpu_wdata` and `cpu_we`, and go to STROBE.
  - `cpu_req` is ignored in every other state (no queueing).
- **STROBE:**
  - Exactly one cycle. `readMem` = !we and `writeMem` = we.
  - `addrBus` holds the registered address.
  - `rdyMem` is ignored in STROBE, so a stale ready from the previous op cannot complete this one.
- **WAIT:**
  - Strobes are low. `addrBus` is held. The wait counter increments on each posedge with `rdyMem` = 0.
- **Completion:** on a posedge in WAIT with `rdyMem` = 1:
  - on a read, `cpu_rdata` ← `outBus`;
  - `cpu_done` = 1 and `cpu_err` = 0 for the next cycle;
  - return to IDLE and clear the counter.
- **Timeout:** on the TIMEOUT-th consecutive WAIT posedge with `rdyMem` = 0:
  - `cpu_done` = 1 and `cpu_err` = 1 for one cycle;
  - `cpu_rdata` is unchanged;
  - return to IDLE.
- **`inBus` drive:**
  - Driven with the registered write data in STROBE and WAIT, only when we = 1.
  - High-Z in IDLE and during every read.
- **`addrBus`:** keeps its last value in IDLE. It is not forced to zero.
- **`cpu_err`:** holds its value until the next `cpu_done`.
- **Wait counter:** width is clog2(TIMEOUT+1). It never wraps, because the abort fires first.

## Timing
- **Reset** (`rst` = 0, immediate and asynchronous):
  - state IDLE, counter 0;
  - `readMem`, `writeMem`, `cpu_busy`, `cpu_done`, `cpu_err` = 0;
  - `addrBus` = 0, `cpu_rdata` = 0, `inBus` = high-Z.
- **Reset mid-transaction:** all of the above apply immediately. No `cpu_done` is produced for the aborted op.
- **Registered outputs:** every output is a register except the tri-state enable. The enable is decoded from registered state, so it is glitch-free.
- **Cycle numbering:** request accepted at edge E0.
  - Strobe is high between E0 and E1.
  - The earliest completion sample is at E2, so `cpu_done` is high between E2 and E3.
  - Minimum latency from request to done is 2 cycles. `cpu_busy` is high from E0 to the done edge.
- **Back-to-back requests:**
  - A new `cpu_req` is accepted at the first posedge in IDLE, i.e. the edge ending the `cpu_done` cycle.
  - Back-to-back throughput is one op per 3 cycles minimum.
- **Timeout latency:** with `rdyMem` stuck low, `cpu_done` with `cpu_err` rises at edge E(1+TIMEOUT).
- **`rdyMem` in STROBE:** if `rdyMem` = 1 in STROBE and is still 1 at E2, the op completes at E2.

## Test plan
- **Writes:** write 0x000C to address 3, then 0xFE0F to 10, then 0xFFFF to 255, against a `Memory` model.
  - Each op gives a single `writeMem` pulse, the correct `addrBus`, and `inBus` = data from STROBE until done.
  - `inBus` is high-Z in IDLE, and `cpu_err` = 0.
- **Reads:** read addresses 3, 10 and 255 after the writes.
  - `cpu_rdata` = 0x000C, 0xFE0F, 0xFFFF respectively, each with a single `readMem` pulse.
  - The block never drives `inBus` during a read.
- **Minimum latency:** `rdyMem` model answers at E2.
  - `cpu_done` is high only between E2 and E3.
  - A second request held high is accepted at E3 and not earlier; a request asserted while busy produces no extra strobe.
- **Timeout:** `rdyMem` tied 0, TIMEOUT = 4, read to address 20.
  - `cpu_done` = 1 and `cpu_err` = 1 at E5.
  - `cpu_rdata` keeps its previous value, and the next request proceeds normally with `cpu_err` = 0.
- **Reset mid-write:** assert `rst` = 0 in WAIT of a write to address 10.
  - Immediately: `writeMem` = 0, `inBus` = high-Z, `cpu_busy` = 0, `addrBus` = 0.
  - No `cpu_done` occurs.
